// File: rtl/prog_sequencer_pkg.sv
// Shared types and default sizing for the program sequencer.
package seq_pkg;

  localparam int unsigned NUM_PROG = 3;
  localparam int unsigned PC_W     = 10;
  localparam int unsigned CYC_W    = 16;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LAUNCH,
    ARM,
    RUN,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; reports the value the next
// increment produces and whether that value is the terminal (all-ones) count.
module sat_counter #(
  parameter int unsigned WIDTH = seq_pkg::CYC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] next_count_c,
  output logic             tc_c
);

  logic [WIDTH-1:0] count;

  assign next_count_c = (count == '1) ? count : count + WIDTH'(1);
  assign tc_c         = (next_count_c == '1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next_count_c;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Runs each enabled program slot on the core in turn, records per-slot cycle
// counts and aborts a slot whose run reaches the all-ones cycle count.
module prog_sequencer #(
  parameter int unsigned NUM_PROG = seq_pkg::NUM_PROG,
  parameter int unsigned PC_W     = seq_pkg::PC_W,
  parameter int unsigned CYC_W    = seq_pkg::CYC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [NUM_PROG-1:0]      prog_en,
  input  logic [NUM_PROG*PC_W-1:0] start_pc_flat,
  output logic                     core_req,
  output logic [PC_W-1:0]          core_pc,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     seq_done,
  output logic [1:0]               cur_prog,
  input  logic [1:0]               cnt_sel,
  output logic [CYC_W-1:0]         cyc_cnt,
  output logic [NUM_PROG-1:0]      timeout_flag
);

  import seq_pkg::seq_state_t, seq_pkg::IDLE, seq_pkg::SELECT, seq_pkg::LAUNCH,
         seq_pkg::ARM, seq_pkg::RUN, seq_pkg::FINISH;

  seq_state_t                     state_q, state_n;
  logic [NUM_PROG-1:0]            en_q, en_n;
  logic [NUM_PROG*PC_W-1:0]       pc_q, pc_n;
  logic [1:0]                     cur_q, cur_n;
  logic [NUM_PROG-1:0][CYC_W-1:0] cnt_q, cnt_n;
  logic [NUM_PROG-1:0]            flag_q, flag_n;
  logic                           req_n, busy_n, done_n;
  logic [PC_W-1:0]                core_pc_n;

  logic                           run_clr, run_en, run_tc;
  logic [CYC_W-1:0]               run_inc;
  logic                           found;
  logic [1:0]                     sel;

  sat_counter #(.WIDTH(CYC_W)) u_run_cnt (
    .clk          (clk),
    .reset        (reset),
    .clear        (run_clr),
    .enable       (run_en),
    .next_count_c (run_inc),
    .tc_c         (run_tc)
  );

  // Lowest enabled slot at or above the current slot index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = int'(NUM_PROG) - 1; i >= 0; i--) begin
      if (en_q[i] && (2'(i) >= cur_q)) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    en_n      = en_q;
    pc_n      = pc_q;
    cur_n     = cur_q;
    cnt_n     = cnt_q;
    flag_n    = flag_q;
    req_n     = 1'b0;
    done_n    = 1'b0;
    core_pc_n = core_pc;
    run_clr   = 1'b0;
    run_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          en_n    = prog_en;
          pc_n    = start_pc_flat;
          cnt_n   = '0;
          flag_n  = '0;
          cur_n   = '0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          cur_n   = sel;
          req_n   = 1'b1;
          state_n = LAUNCH;
          for (int i = 0; i < int'(NUM_PROG); i++) begin
            if (sel == 2'(i)) core_pc_n = pc_q[i*PC_W +: PC_W];
          end
        end else begin
          done_n  = 1'b1;
          state_n = FINISH;
        end
      end
      LAUNCH: state_n = ARM;
      // Holding the counter clear here also masks a done left over from the
      // previous program.
      ARM: begin
        run_clr = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        run_en = 1'b1;
        if (core_done || run_tc) begin
          for (int i = 0; i < int'(NUM_PROG); i++) begin
            if (cur_q == 2'(i)) begin
              cnt_n[i] = run_inc;
              if (!core_done) flag_n[i] = 1'b1;
            end
          end
          cur_n   = cur_q + 2'd1;
          state_n = SELECT;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= '0;
      pc_q     <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      flag_q   <= '0;
      core_req <= 1'b0;
      core_pc  <= '0;
      busy     <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state_q  <= state_n;
      en_q     <= en_n;
      pc_q     <= pc_n;
      cur_q    <= cur_n;
      cnt_q    <= cnt_n;
      flag_q   <= flag_n;
      core_req <= req_n;
      core_pc  <= core_pc_n;
      busy     <= busy_n;
      seq_done <= done_n;
    end
  end

  // Count read port; unpopulated selects read as zero.
  always_comb begin
    cyc_cnt = '0;
    for (int i = 0; i < int'(NUM_PROG); i++) begin
      if (cnt_sel == 2'(i)) cyc_cnt = cnt_q[i];
    end
  end

  assign cur_prog     = cur_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench: default-size sequencer plus a 4-bit-counter instance for
// timeout and terminal-count cases.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        go_a, req_a, done_a, busy_a, sdone_a;
  logic [2:0]  en_a, flag_a;
  logic [29:0] pcs_a;
  logic [9:0]  pc_a;
  logic [1:0]  cur_a, sel_a;
  logic [15:0] cnt_a;

  logic        go_b, req_b, done_b, busy_b, sdone_b;
  logic [2:0]  en_b, flag_b;
  logic [29:0] pcs_b;
  logic [9:0]  pc_b;
  logic [1:0]  cur_b, sel_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_sequencer u_dut_a (
    .clk(clk), .reset(reset), .go(go_a), .prog_en(en_a), .start_pc_flat(pcs_a),
    .core_req(req_a), .core_pc(pc_a), .core_done(done_a), .busy(busy_a),
    .seq_done(sdone_a), .cur_prog(cur_a), .cnt_sel(sel_a), .cyc_cnt(cnt_a),
    .timeout_flag(flag_a)
  );

  prog_sequencer #(.CYC_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .go(go_b), .prog_en(en_b), .start_pc_flat(pcs_b),
    .core_req(req_b), .core_pc(pc_b), .core_done(done_b), .busy(busy_b),
    .seq_done(sdone_b), .cur_prog(cur_b), .cnt_sel(sel_b), .cyc_cnt(cnt_b),
    .timeout_flag(flag_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the launch of one slot, checks it, then plays a core that
  // raises done in RUN cycle k. Returns at the negedge of the following SELECT.
  task automatic run_slot_a(input logic [9:0] exp_pc, input logic [1:0] exp_slot,
                            input int k, input logic stale, input int exp_wait);
    int w = 0;
    while (!req_a && w < 20) begin @(negedge clk); w++; end
    chk("a_launch_wait", 32'(w), 32'(exp_wait));
    chk("a_core_req", 32'(req_a), 1);
    chk("a_core_pc", 32'(pc_a), 32'(exp_pc));
    chk("a_cur_prog", 32'(cur_a), 32'(exp_slot));
    done_a = stale;
    @(negedge clk);
    for (int c = 1; c <= k; c++) begin @(negedge clk); done_a = (c == k); end
    @(negedge clk);
    done_a = 1'b0;
  endtask

  task automatic run_slot_b(input logic [9:0] exp_pc, input logic [1:0] exp_slot,
                            input int k, input int exp_wait);
    int w = 0;
    while (!req_b && w < 20) begin @(negedge clk); w++; end
    chk("b_launch_wait", 32'(w), 32'(exp_wait));
    chk("b_core_pc", 32'(pc_b), 32'(exp_pc));
    chk("b_cur_prog", 32'(cur_b), 32'(exp_slot));
    done_b = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= k; c++) begin @(negedge clk); done_b = (c == k); end
    @(negedge clk);
    done_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b0;
    go_a = 0; en_a = '0; pcs_a = '0; done_a = 0; sel_a = '0;
    go_b = 0; en_b = '0; pcs_b = '0; done_b = 0; sel_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_core_req", 32'(req_a), 0);
    chk("rst_core_pc", 32'(pc_a), 0);
    chk("rst_seq_done", 32'(sdone_a), 0);
    chk("rst_cur_prog", 32'(cur_a), 0);
    chk("rst_flags", 32'(flag_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);

    // All three slots, done after 5/7/9 RUN cycles
    en_a = 3'b111; pcs_a = {10'd200, 10'd100, 10'd0}; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    chk("t1_select_busy", 32'(busy_a), 1);
    chk("t1_select_req", 32'(req_a), 0);
    run_slot_a(10'd0,   2'd0, 5, 1'b0, 1);
    run_slot_a(10'd100, 2'd1, 7, 1'b0, 1);
    run_slot_a(10'd200, 2'd2, 9, 1'b0, 1);
    chk("t1_cur_end", 32'(cur_a), 3);
    chk("t1_sdone_early", 32'(sdone_a), 0);
    @(negedge clk);
    chk("t1_sdone", 32'(sdone_a), 1);
    chk("t1_finish_busy", 32'(busy_a), 1);
    @(negedge clk);
    chk("t1_sdone_pulse", 32'(sdone_a), 0);
    chk("t1_idle_busy", 32'(busy_a), 0);
    sel_a = 2'd0; #1 chk("t1_cnt0", 32'(cnt_a), 5);
    sel_a = 2'd1; #1 chk("t1_cnt1", 32'(cnt_a), 7);
    sel_a = 2'd2; #1 chk("t1_cnt2", 32'(cnt_a), 9);
    sel_a = 2'd3; #1 chk("t1_cnt3", 32'(cnt_a), 0);
    chk("t1_flags", 32'(flag_a), 0);

    // Slot 1 disabled; a second go mid-sequence is ignored
    @(negedge clk);
    en_a = 3'b101; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    run_slot_a(10'd0, 2'd0, 3, 1'b0, 1);
    chk("t2_cur_after0", 32'(cur_a), 1);
    go_a = 1'b1;
    run_slot_a(10'd200, 2'd2, 2, 1'b0, 1);
    go_a = 1'b0;
    @(negedge clk);
    chk("t2_sdone", 32'(sdone_a), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_no_req", 32'(req_a), 0);
      chk("t2_no_sdone", 32'(sdone_a), 0);
    end
    sel_a = 2'd0; #1 chk("t2_cnt0", 32'(cnt_a), 3);
    sel_a = 2'd1; #1 chk("t2_cnt1", 32'(cnt_a), 0);
    sel_a = 2'd2; #1 chk("t2_cnt2", 32'(cnt_a), 2);

    // Stale done held high through SELECT/LAUNCH/ARM
    @(negedge clk);
    en_a = 3'b001; done_a = 1'b1; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    run_slot_a(10'd0, 2'd0, 4, 1'b1, 1);
    @(negedge clk);
    chk("t4_sdone", 32'(sdone_a), 1);
    sel_a = 2'd0; #1 chk("t4_cnt0", 32'(cnt_a), 4);
    chk("t4_flags", 32'(flag_a), 0);

    // Reset in the middle of slot 1's RUN
    @(negedge clk);
    en_a = 3'b111; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    run_slot_a(10'd0, 2'd0, 2, 1'b0, 1);
    @(negedge clk);
    chk("t5_req1", 32'(req_a), 1);
    @(negedge clk);
    @(negedge clk);
    sel_a = 2'd0; #1 chk("t5_cnt0_pre", 32'(cnt_a), 2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_req", 32'(req_a), 0);
    chk("t5_cur", 32'(cur_a), 0);
    chk("t5_pc", 32'(pc_a), 0);
    chk("t5_cnt0", 32'(cnt_a), 0);
    chk("t5_flags", 32'(flag_a), 0);
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy_a), 0);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    run_slot_a(10'd0,   2'd0, 1, 1'b0, 1);
    run_slot_a(10'd100, 2'd1, 1, 1'b0, 1);
    run_slot_a(10'd200, 2'd2, 1, 1'b0, 1);
    @(negedge clk);
    chk("t5_sdone", 32'(sdone_a), 1);
    sel_a = 2'd1; #1 chk("t5_min_cnt1", 32'(cnt_a), 1);

    // Nothing enabled: seq_done two cycles after go, no core_req
    @(negedge clk);
    @(negedge clk);
    en_a = 3'b000; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    chk("t6_sel_sdone", 32'(sdone_a), 0);
    chk("t6_sel_busy", 32'(busy_a), 1);
    @(negedge clk);
    chk("t6_sdone", 32'(sdone_a), 1);
    chk("t6_req", 32'(req_a), 0);
    @(negedge clk);
    chk("t6_sdone_off", 32'(sdone_a), 0);
    chk("t6_busy_off", 32'(busy_a), 0);

    // 4-bit counter: slot 0 hangs and times out, slot 1 done after 3
    en_b = 3'b011; pcs_b = {10'd9, 10'd3, 10'd1}; go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    w = 0;
    while (!req_b && w < 20) begin @(negedge clk); w++; end
    chk("b0_launch_wait", 32'(w), 1);
    chk("b0_pc", 32'(pc_b), 1);
    @(negedge clk);
    w = 1;
    while (!req_b && w < 40) begin @(negedge clk); w++; end
    chk("b0_timeout_gap", 32'(w), 18);
    run_slot_b(10'd3, 2'd1, 3, 0);
    @(negedge clk);
    chk("b_sdone", 32'(sdone_b), 1);
    chk("b_flags", 32'(flag_b), 3'b001);
    sel_b = 2'd0; #1 chk("b_cnt0", 32'(cnt_b), 15);
    sel_b = 2'd1; #1 chk("b_cnt1", 32'(cnt_b), 3);
    sel_b = 2'd2; #1 chk("b_cnt2", 32'(cnt_b), 0);

    // Done on the terminal cycle: done wins, no timeout flag
    @(negedge clk);
    en_b = 3'b100; go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    run_slot_b(10'd9, 2'd2, 15, 1);
    @(negedge clk);
    chk("b2_sdone", 32'(sdone_b), 1);
    chk("b2_flags", 32'(flag_b), 0);
    sel_b = 2'd2; #1 chk("b2_cnt2", 32'(cnt_b), 15);
    sel_b = 2'd0; #1 chk("b2_cnt0", 32'(cnt_b), 0);
    sel_b = 2'd3; #1 chk("b2_cnt3", 32'(cnt_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
